// File: rtl/uart_echo_core_pkg.sv
// Shared state encodings and divider arithmetic for the UART echo core.
package uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StStart = 2'd1;
  localparam state_t StData  = 2'd2;
  localparam state_t StStop  = 2'd3;

  function automatic int unsigned bit_div(input int unsigned clk_freq,
                                          input int unsigned baudrate);
    return clk_freq / baudrate;
  endfunction

  function automatic int unsigned sample_div(input int unsigned bdiv,
                                             input int unsigned nsamples);
    return bdiv / nsamples;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned bdiv);
    return (bdiv > 1) ? $clog2(bdiv) : 1;
  endfunction

endpackage

// File: rtl/uart_echo_core_tx.sv
// 8N1 transmitter: START, 8 data bits LSB first, STOP; each bit lasts BIT_DIV cycles.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx,
  output logic       done
);

  localparam int unsigned CntW = cnt_width(BIT_DIV);
  localparam logic [CntW-1:0] BitLast = CntW'(BIT_DIV - 1);

  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      shreg_q;
  logic [2:0]      bit_idx_q;
  logic            bit_end;
  logic            last_stop;
  logic            accept;

  assign bit_end   = (cnt_q == BitLast);
  assign last_stop = (state_q == StStop) && bit_end;
  // Free during the final stop cycle so a waiting byte starts with no idle gap.
  assign busy      = (state_q != StIdle) && !last_stop;
  assign accept    = load && !busy;
  assign done      = last_stop;

  always_comb begin
    tx = 1'b1;
    case (state_q)
      StStart: tx = 1'b0;
      StData:  tx = shreg_q[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      bit_idx_q <= '0;
    end else if (accept) begin
      state_q   <= StStart;
      cnt_q     <= '0;
      shreg_q   <= data;
      bit_idx_q <= '0;
    end else if (state_q != StIdle) begin
      if (!bit_end) begin
        cnt_q <= cnt_q + CntW'(1);
      end else begin
        cnt_q <= '0;
        case (state_q)
          StStart: state_q <= StData;
          StData: begin
            shreg_q   <= {1'b0, shreg_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= StStop;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_echo_core.sv
// UART 8N1 receiver with majority-vote oversampling; every good byte is echoed on tx.
module uart_echo_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned BAUDRATE      = 19200,
  parameter int unsigned NO_RX_SAMPLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       rx_sample_clk,
  output logic       tx_data_out,
  output logic       tx_data_done
);

  localparam int unsigned BitDiv    = bit_div(CLK_FREQ, BAUDRATE);
  localparam int unsigned SampleDiv = sample_div(BitDiv, NO_RX_SAMPLES);
  localparam int unsigned CntW      = cnt_width(BitDiv);
  localparam int unsigned SampW     = $clog2(NO_RX_SAMPLES + 1);
  localparam logic [CntW-1:0]  SampLast = CntW'(SampleDiv - 1);
  localparam logic [CntW-1:0]  SampHalf = CntW'(SampleDiv / 2);
  localparam logic [SampW-1:0] SampMax  = SampW'(NO_RX_SAMPLES - 1);
  localparam logic [SampW-1:0] Majority = SampW'(NO_RX_SAMPLES / 2);

  logic [1:0]       sync_q;
  logic             rx_prev_q;
  logic             rx_s;
  logic             fall;
  state_t           rx_state_q;
  logic [CntW-1:0]  scnt_q;
  logic [SampW-1:0] samp_idx_q;
  logic [SampW-1:0] ones_q;
  logic [SampW-1:0] ones_total;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic [7:0]       rx_data_q;
  logic             ready_q;
  logic             tick;
  logic             last_sample;
  logic             vote;
  logic [7:0]       buf_data_q;
  logic             buf_valid_q;
  logic             tx_busy;
  logic             take;

  assign rx_s        = sync_q[1];
  assign fall        = rx_prev_q && !rx_s;
  assign tick        = (rx_state_q != StIdle) && (scnt_q == SampLast);
  assign last_sample = (samp_idx_q == SampMax);
  assign ones_total  = ones_q + SampW'(rx_s);
  assign vote        = (ones_total > Majority);

  assign rx_data       = rx_data_q;
  assign rx_data_ready = ready_q;
  assign rx_sample_clk = tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_in};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= StIdle;
      scnt_q     <= '0;
      samp_idx_q <= '0;
      ones_q     <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      ready_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (rx_state_q == StIdle) begin
        // Half-period preload centres the samples within each bit.
        if (fall) begin
          scnt_q     <= SampHalf;
          samp_idx_q <= '0;
          ones_q     <= '0;
          rx_state_q <= StStart;
        end
      end else if (!tick) begin
        scnt_q <= scnt_q + CntW'(1);
      end else begin
        scnt_q <= '0;
        if (!last_sample) begin
          samp_idx_q <= samp_idx_q + SampW'(1);
          ones_q     <= ones_total;
        end else begin
          samp_idx_q <= '0;
          ones_q     <= '0;
          case (rx_state_q)
            StStart: begin
              bit_idx_q  <= '0;
              rx_state_q <= vote ? StIdle : StData;
            end
            StData: begin
              shreg_q   <= {vote, shreg_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) rx_state_q <= StStop;
            end
            default: begin
              if (vote) begin
                rx_data_q <= shreg_q;
                ready_q   <= 1'b1;
              end
              rx_state_q <= StIdle;
            end
          endcase
        end
      end
    end
  end

  assign take = buf_valid_q && !tx_busy;

  // A take in the same cycle as a write leaves the buffer empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      if (ready_q) buf_data_q <= rx_data_q;
      if (take) begin
        buf_valid_q <= 1'b0;
      end else if (ready_q) begin
        buf_valid_q <= 1'b1;
      end
    end
  end

  uart_tx #(
    .BIT_DIV(BitDiv)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .load (take),
    .data (buf_data_q),
    .busy (tx_busy),
    .tx   (tx_data_out),
    .done (tx_data_done)
  );

endmodule

// File: tb/tb_uart_echo_core.sv
// Scoreboard bench for uart_echo_core with a fast baud rate (100 clocks per bit).
module tb_uart_echo_core;

  localparam int unsigned CLK_FREQ = 2_000_000;
  localparam int unsigned BAUDRATE = 20_000;
  localparam int unsigned NSAMP    = 5;
  localparam int BIT  = 100;
  localparam int SAMP = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       rx_sample_clk;
  logic       tx_data_out;
  logic       tx_data_done;

  always #5 clk = ~clk;

  uart_echo_core #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUDRATE     (BAUDRATE),
    .NO_RX_SAMPLES(NSAMP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_data_ready(rx_data_ready),
    .rx_sample_clk(rx_sample_clk),
    .tx_data_out  (tx_data_out),
    .tx_data_done (tx_data_done)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];
  int rx_ready_cnt = 0;
  int ready_cyc = 0;
  int tx_start_cnt = 0;
  int tx_start_cyc = 0;
  int sample_cnt = 0;

  logic       tx_active = 1'b0;
  logic       tx_unexp = 1'b0;
  logic       tx_bad;
  logic       done_bad;
  logic [7:0] tx_exp;
  logic [7:0] tx_cap;
  int         tx_t;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // RX monitor: every ready pulse must match the oldest byte sent.
  always @(negedge clk) begin
    if (!rst && rx_sample_clk) sample_cnt++;
    if (!rst && rx_data_ready) begin
      rx_ready_cnt++;
      ready_cyc = cyc;
      if (rx_exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rx_unexpected: got byte %02h, expected no byte", rx_data);
      end else begin
        check("rx_data", {24'd0, rx_data}, {24'd0, rx_exp_q.pop_front()});
      end
    end
  end

  // TX monitor: compares the whole line waveform of each frame against the expected byte.
  always @(negedge clk) begin
    if (rst) begin
      tx_active = 1'b0;
    end else begin
      if (!tx_active) begin
        if (tx_data_done) check("tx_done_while_idle", {31'd0, tx_data_done}, 32'd0);
        if (tx_data_out == 1'b0) begin
          tx_active = 1'b1;
          tx_t = 0;
          tx_bad = 1'b0;
          done_bad = 1'b0;
          tx_cap = 8'h00;
          tx_start_cnt++;
          tx_start_cyc = cyc;
          if (tx_exp_q.size() == 0) begin
            tx_unexp = 1'b1;
            tx_exp = 8'h00;
            vectors++;
            miscompares++;
            $display("FAIL tx_unexpected: got a start bit, expected an idle line");
          end else begin
            tx_unexp = 1'b0;
            tx_exp = tx_exp_q.pop_front();
          end
        end
      end
      if (tx_active) begin
        automatic int b = tx_t / BIT;
        automatic logic lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : tx_exp[b-1];
        if (tx_data_out !== lvl) tx_bad = 1'b1;
        if ((tx_t % BIT) == BIT / 2 && b >= 1 && b <= 8) tx_cap[b-1] = tx_data_out;
        if (tx_data_done !== (tx_t == 10 * BIT - 1)) done_bad = 1'b1;
        tx_t++;
        if (tx_t == 10 * BIT) begin
          tx_active = 1'b0;
          if (!tx_unexp) begin
            vectors++;
            if (tx_bad) begin
              miscompares++;
              $display("FAIL tx_frame: got waveform of byte %02h, expected byte %02h",
                       tx_cap, tx_exp);
            end
            check("tx_done_timing", {31'd0, done_bad}, 32'd0);
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = f[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((tx_active || tx_exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, n < budget}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within 100000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, t0, s0, n;
    logic [7:0] fixed[6];
    logic [7:0] b;
    fixed = '{8'h55, 8'h5A, 8'h97, 8'hAA, 8'hFF, 8'h01};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_data_ready", {31'd0, rx_data_ready}, 32'd0);
    check("rst_rx_sample_clk", {31'd0, rx_sample_clk}, 32'd0);
    check("rst_tx_data_out", {31'd0, tx_data_out}, 32'd1);
    check("rst_tx_data_done", {31'd0, tx_data_done}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single 0x55 frame, sample pulse count and echo latency.
    s0 = sample_cnt; r0 = rx_ready_cnt; t0 = tx_start_cnt;
    rx_exp_q.push_back(8'h55); tx_exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    rx_in = 1'b1;
    check("single_ready_count", rx_ready_cnt - r0, 32'd1);
    check("sample_pulses", sample_cnt - s0, 32'd50);
    n = 0;
    while (tx_start_cnt == t0 && n < 50) begin @(negedge clk); n++; end
    check("tx_start_latency_le2",
          {31'd0, (tx_start_cnt > t0) && (tx_start_cyc - ready_cyc >= 1) &&
                  (tx_start_cyc - ready_cyc <= 2)}, 32'd1);
    drain(1200, "drain_single");

    // One-sample-period glitch must not start a frame.
    r0 = rx_ready_cnt; t0 = tx_start_cnt;
    rx_in = 1'b0;
    repeat (SAMP) @(negedge clk);
    rx_in = 1'b1;
    repeat (15 * BIT) @(negedge clk);
    check("glitch_ready_count", rx_ready_cnt - r0, 32'd0);
    check("glitch_tx_starts", tx_start_cnt - t0, 32'd0);

    // Framing error is dropped; the next good frame is received and echoed.
    r0 = rx_ready_cnt; t0 = tx_start_cnt;
    send_frame(8'hA5, 1'b0);
    rx_in = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("framing_err_ready_count", rx_ready_cnt - r0, 32'd0);
    rx_exp_q.push_back(8'h97); tx_exp_q.push_back(8'h97);
    send_frame(8'h97, 1'b1);
    rx_in = 1'b1;
    repeat (BIT) @(negedge clk);
    check("after_err_ready_count", rx_ready_cnt - r0, 32'd1);
    drain(1200, "drain_framing");
    check("after_err_tx_starts", tx_start_cnt - t0, 32'd1);

    // Back-to-back frames with zero idle gap: fixed pattern then random bytes.
    r0 = rx_ready_cnt; t0 = tx_start_cnt;
    for (int i = 0; i < 36; i++) begin
      b = (i < 6) ? fixed[i] : 8'($urandom_range(255));
      rx_exp_q.push_back(b); tx_exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    rx_in = 1'b1;
    repeat (BIT) @(negedge clk);
    drain(2500, "drain_b2b");
    check("b2b_ready_count", rx_ready_cnt - r0, 32'd36);
    check("b2b_tx_starts", tx_start_cnt - t0, 32'd36);

    // Reset in the middle of an echo: line high at once, no echo afterwards.
    rx_exp_q.push_back(8'h3C); tx_exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    rx_in = 1'b1;
    n = 0;
    while (!tx_active && n < 50) begin @(negedge clk); n++; end
    check("mid_tx_started", {31'd0, tx_active}, 32'd1);
    repeat (3 * BIT + 37) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midtx_rst_tx_data_out", {31'd0, tx_data_out}, 32'd1);
    check("midtx_rst_rx_data_ready", {31'd0, rx_data_ready}, 32'd0);
    check("midtx_rst_tx_data_done", {31'd0, tx_data_done}, 32'd0);
    check("midtx_rst_rx_sample_clk", {31'd0, rx_sample_clk}, 32'd0);
    check("midtx_rst_rx_data", {24'd0, rx_data}, 32'd0);
    tx_exp_q.delete();
    t0 = tx_start_cnt;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (15 * BIT) @(negedge clk);
    check("post_rst_tx_starts", tx_start_cnt - t0, 32'd0);
    check("post_rst_tx_idle", {31'd0, tx_data_out}, 32'd1);
    check("rx_leftover", rx_exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
